// File: rtl/branch_history_predictor.sv
// Dynamic branch predictor: Fetch-stage prediction of B-type branches, an in-flight FIFO of
// predictions resolved in Execute, and mispredict flush/redirect. Modes: static BTFN, fwd/bwd, PHT.
module branch_history_predictor #(
    parameter int DATA_WIDTH   = 32,
    parameter int PHT_ENTRIES  = 64,
    parameter int QUEUE_DEPTH  = 4,
    parameter int PREDICT_MODE = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_WIDTH-1:0]          RD,
    input  logic [DATA_WIDTH-1:0]          PCF,
    input  logic                           StallF,
    input  logic                           BranchE,
    input  logic                           ZeroE,
    output logic [DATA_WIDTH-1:0]          PCBPU,
    output logic                           PCBPUSrc,
    output logic                           flushBranch,
    output logic                           bpu_err,
    output logic [$clog2(QUEUE_DEPTH):0]   o_dbg_count
);

    localparam int IDX_W = $clog2(PHT_ENTRIES);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [1:0]            r_pht [PHT_ENTRIES];
    logic [1:0]            r_fwd;
    logic [1:0]            r_bwd;

    logic [DATA_WIDTH-1:0] r_q_pc   [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] r_q_tgt  [QUEUE_DEPTH];
    logic [IDX_W-1:0]      r_q_idx  [QUEUE_DEPTH];
    logic                  r_q_dir  [QUEUE_DEPTH];
    logic                  r_q_pred [QUEUE_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_err;

    logic                  w_is_branch;
    logic [DATA_WIDTH-1:0] w_imm;
    logic [DATA_WIDTH-1:0] w_target;
    logic [IDX_W-1:0]      w_idx;
    logic [1:0]            w_ctr;
    logic                  w_pred_raw;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_resolve;
    logic                  w_mispredict;
    logic                  w_pred;
    logic                  w_push;
    logic                  w_overflow;
    logic                  w_underflow;
    logic [DATA_WIDTH-1:0] w_head_pc;
    logic [DATA_WIDTH-1:0] w_head_tgt;
    logic [IDX_W-1:0]      w_head_idx;
    logic                  w_head_dir;
    logic                  w_head_pred;
    logic                  w_unused_bits;

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        if (taken) return (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        else       return (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    endfunction

    assign w_unused_bits = ^RD[24:12];

    assign w_is_branch = (RD[6:0] == 7'b1100011);
    assign w_imm       = {{(DATA_WIDTH-12){RD[31]}}, RD[7], RD[30:25], RD[11:8], 1'b0};
    assign w_target    = PCF + w_imm;
    assign w_idx       = PCF[IDX_W+1:2];

    assign w_ctr       = (PREDICT_MODE == 2) ? r_pht[w_idx] : (RD[31] ? r_bwd : r_fwd);
    assign w_pred_raw  = (PREDICT_MODE == 0) ? RD[31] : w_ctr[1];

    assign w_head_pc   = r_q_pc[r_rd_ptr];
    assign w_head_tgt  = r_q_tgt[r_rd_ptr];
    assign w_head_idx  = r_q_idx[r_rd_ptr];
    assign w_head_dir  = r_q_dir[r_rd_ptr];
    assign w_head_pred = r_q_pred[r_rd_ptr];

    assign w_full       = (r_count == CNT_W'(QUEUE_DEPTH));
    assign w_empty      = (r_count == '0);
    assign w_resolve    = BranchE && !w_empty;
    assign w_mispredict = w_resolve && (w_head_pred != ZeroE);
    // A full FIFO cannot track another prediction, so it is forced not-taken.
    assign w_pred       = w_is_branch && w_pred_raw && !w_full;
    assign w_push       = w_is_branch && !StallF && !w_mispredict && !w_full;
    assign w_overflow   = w_is_branch && !StallF && !w_mispredict && w_full;
    assign w_underflow  = BranchE && w_empty;

    always_comb begin
        PCBPU       = '0;
        PCBPUSrc    = 1'b0;
        flushBranch = 1'b0;
        if (!rst) begin
            if (w_mispredict) begin
                flushBranch = 1'b1;
                PCBPUSrc    = 1'b1;
                PCBPU       = ZeroE ? w_head_tgt : (w_head_pc + DATA_WIDTH'(4));
            end else if (w_pred) begin
                PCBPUSrc = 1'b1;
                PCBPU    = w_target;
            end
        end
    end

    assign bpu_err     = r_err;
    assign o_dbg_count = r_count;

    // FIFO payload needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_wr_ptr]   <= PCF;
            r_q_tgt[r_wr_ptr]  <= w_target;
            r_q_idx[r_wr_ptr]  <= w_idx;
            r_q_dir[r_wr_ptr]  <= RD[31];
            r_q_pred[r_wr_ptr] <= w_pred;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= r_err | w_overflow | w_underflow;
            if (w_mispredict) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push)    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_resolve) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_resolve);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PHT_ENTRIES; i++) r_pht[i] <= 2'b01;
            r_fwd <= 2'b01;
            r_bwd <= 2'b01;
        end else if (w_resolve) begin
            if (PREDICT_MODE == 2) begin
                r_pht[w_head_idx] <= sat_update(r_pht[w_head_idx], ZeroE);
            end else if (PREDICT_MODE == 1) begin
                if (w_head_dir) r_bwd <= sat_update(r_bwd, ZeroE);
                else            r_fwd <= sat_update(r_fwd, ZeroE);
            end
        end
    end

endmodule

// File: tb/tb_branch_history_predictor.sv
// Directed bench for branch_history_predictor in PHT mode: inputs change on the falling edge,
// combinational outputs are sampled 1ns later, state commits on the following rising edge.
module tb_branch_history_predictor;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] BEQ_M8   = 32'hFE00_0CE3;
    localparam logic [31:0] BEQ_P16  = 32'h0000_0863;
    localparam logic [31:0] BEQ_P8   = 32'h0000_0463;

    logic        clk;
    logic        rst;
    logic [31:0] RD;
    logic [31:0] PCF;
    logic        StallF;
    logic        BranchE;
    logic        ZeroE;
    logic [31:0] PCBPU;
    logic        PCBPUSrc;
    logic        flushBranch;
    logic        bpu_err;
    logic [2:0]  dbg_count;

    int n_tests;
    int n_fail;

    branch_history_predictor #(
        .DATA_WIDTH(32), .PHT_ENTRIES(64), .QUEUE_DEPTH(4), .PREDICT_MODE(2)
    ) dut (
        .clk(clk), .rst(rst), .RD(RD), .PCF(PCF), .StallF(StallF),
        .BranchE(BranchE), .ZeroE(ZeroE), .PCBPU(PCBPU), .PCBPUSrc(PCBPUSrc),
        .flushBranch(flushBranch), .bpu_err(bpu_err), .o_dbg_count(dbg_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] rd, input logic [31:0] pc, input logic stall,
                         input logic br, input logic z);
        RD = rd; PCF = pc; StallF = stall; BranchE = br; ZeroE = z;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic src, input logic [31:0] pc,
                           input logic fl);
        chk({tag, "_src"}, {31'd0, PCBPUSrc}, {31'd0, src});
        if (src) chk({tag, "_pc"}, PCBPU, pc);
        chk({tag, "_flush"}, {31'd0, flushBranch}, {31'd0, fl});
    endtask

    task automatic chk_cnt(input string tag, input int exp);
        chk(tag, {29'd0, dbg_count}, exp);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0;
        RD = NOP; PCF = '0; StallF = 1'b0; BranchE = 1'b0; ZeroE = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        drive(BEQ_M8, 32'h100, 1'b0, 1'b1, 1'b1);
        chk("rst_src", {31'd0, PCBPUSrc}, 32'd0);
        chk("rst_flush", {31'd0, flushBranch}, 32'd0);
        chk("rst_pcbpu", PCBPU, 32'd0);
        chk("rst_err", {31'd0, bpu_err}, 32'd0);
        chk_cnt("rst_cnt", 0);
        @(negedge clk);
        rst = 1'b0;

        // 1: first fetch of BEQ -8 at 0x100, weak not-taken
        drive(BEQ_M8, 32'h100, 1'b0, 1'b0, 1'b0);
        chk_out("t1", 1'b0, 32'h0, 1'b0);
        tick();
        chk_cnt("t1_cnt", 1);

        // 2: resolve taken (mispredict, 01->10), refetch taken, resolve taken (10->11)
        drive(NOP, 32'h104, 1'b0, 1'b1, 1'b1);
        chk_out("t2_mp", 1'b1, 32'hF8, 1'b1);
        tick();
        chk_cnt("t2_mp_cnt", 0);
        drive(BEQ_M8, 32'h100, 1'b0, 1'b0, 1'b0);
        chk_out("t2_f2", 1'b1, 32'hF8, 1'b0);
        tick();
        chk_cnt("t2_f2_cnt", 1);
        drive(NOP, 32'hF8, 1'b0, 1'b1, 1'b1);
        chk_out("t2_ok", 1'b0, 32'h0, 1'b0);
        tick();
        chk_cnt("t2_ok_cnt", 0);
        drive(BEQ_M8, 32'h100, 1'b1, 1'b0, 1'b0);
        chk_out("t2_f3", 1'b1, 32'hF8, 1'b0);
        tick();
        chk_cnt("t2_stall_cnt", 0);

        // 3: train 0x40 to 11, then mispredict not-taken while a taken fetch is present
        drive(BEQ_P16, 32'h40, 1'b0, 1'b0, 1'b0);
        chk_out("t3_f1", 1'b0, 32'h0, 1'b0);
        tick();
        drive(NOP, 32'h44, 1'b0, 1'b1, 1'b1);
        chk_out("t3_mp1", 1'b1, 32'h50, 1'b1);
        tick();
        drive(BEQ_P16, 32'h40, 1'b0, 1'b0, 1'b0);
        chk_out("t3_f2", 1'b1, 32'h50, 1'b0);
        tick();
        drive(NOP, 32'h50, 1'b0, 1'b1, 1'b1);
        chk_out("t3_ok", 1'b0, 32'h0, 1'b0);
        tick();
        drive(BEQ_P16, 32'h40, 1'b0, 1'b0, 1'b0);
        chk_out("t3_f3", 1'b1, 32'h50, 1'b0);
        tick();
        chk_cnt("t3_f3_cnt", 1);
        drive(BEQ_M8, 32'h100, 1'b0, 1'b1, 1'b0);
        chk_out("t3_mp2", 1'b1, 32'h44, 1'b1);
        tick();
        chk_cnt("t3_mp2_cnt", 0);
        drive(BEQ_P16, 32'h40, 1'b1, 1'b0, 1'b0);
        chk_out("t3_ctr10", 1'b1, 32'h50, 1'b0);
        tick();

        // 4: fill the FIFO, fifth fetch (would predict taken) is forced not-taken
        drive(BEQ_P8, 32'h204, 1'b0, 1'b0, 1'b0); tick();
        drive(BEQ_P8, 32'h208, 1'b0, 1'b0, 1'b0); tick();
        drive(BEQ_P8, 32'h20C, 1'b0, 1'b0, 1'b0); tick();
        drive(BEQ_P8, 32'h210, 1'b0, 1'b0, 1'b0);
        tick();
        chk_cnt("t4_full_cnt", 4);
        chk("t4_err_pre", {31'd0, bpu_err}, 32'd0);
        drive(BEQ_M8, 32'h100, 1'b0, 1'b0, 1'b0);
        chk_out("t4_full", 1'b0, 32'h0, 1'b0);
        tick();
        chk("t4_err", {31'd0, bpu_err}, 32'd1);
        chk_cnt("t4_cnt", 4);

        // 5: pop one, then push and pop together; head moves to 0x20C
        drive(NOP, 32'h300, 1'b0, 1'b1, 1'b0);
        chk_out("t5_pop", 1'b0, 32'h0, 1'b0);
        tick();
        chk_cnt("t5_pop_cnt", 3);
        drive(BEQ_P8, 32'h214, 1'b0, 1'b1, 1'b0);
        chk_out("t5_pp", 1'b0, 32'h0, 1'b0);
        tick();
        chk_cnt("t5_pp_cnt", 3);
        drive(NOP, 32'h304, 1'b0, 1'b1, 1'b1);
        chk_out("t5_head", 1'b1, 32'h214, 1'b1);
        tick();
        chk_cnt("t5_head_cnt", 0);
        chk("t5_err_sticky", {31'd0, bpu_err}, 32'd1);

        // 6: three entries queued, async reset mid-stream
        drive(BEQ_P8, 32'h218, 1'b0, 1'b0, 1'b0); tick();
        drive(BEQ_P8, 32'h21C, 1'b0, 1'b0, 1'b0); tick();
        drive(BEQ_P8, 32'h220, 1'b0, 1'b0, 1'b0); tick();
        chk_cnt("t6_pre_cnt", 3);
        drive(NOP, 32'h400, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk_cnt("t6_rst_cnt", 0);
        chk("t6_rst_err", {31'd0, bpu_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(NOP, 32'h404, 1'b0, 1'b1, 1'b1);
        chk_out("t6_empty_br", 1'b0, 32'h0, 1'b0);
        tick();
        chk("t6_err", {31'd0, bpu_err}, 32'd1);
        chk_cnt("t6_cnt", 0);
        drive(BEQ_M8, 32'h100, 1'b1, 1'b0, 1'b0);
        chk_out("t6_ctr100", 1'b0, 32'h0, 1'b0);
        drive(BEQ_P16, 32'h40, 1'b1, 1'b0, 1'b0);
        chk_out("t6_ctr40", 1'b0, 32'h0, 1'b0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
